// File: rtl/usb_pkg.sv
// Shared definitions for the USB transmit packetizer: PID codes, SYNC byte,
// CRC16 constants and the FSM state type. The CRC states exist only when
// USB_TX_CRC16_EN is defined.
package usb_pkg;

    typedef enum logic [3:0] {
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010,
        PID_STALL = 4'b1110,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011
    } pid_t;

    localparam logic [7:0]  SYNC_BYTE   = 8'h80;
    localparam logic [15:0] CRC16_POLY  = 16'h8005;
    localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
    localparam logic [6:0]  MAX_PAYLOAD = 7'd64;

`ifdef USB_TX_CRC16_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_SYNC, ST_PID, ST_DATA, ST_CRC_LO, ST_CRC_HI
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_SYNC, ST_PID, ST_DATA
    } state_t;
`endif

    function automatic logic is_data_pid(input logic [3:0] p);
        return (p == PID_DATA0) || (p == PID_DATA1);
    endfunction

    function automatic logic is_handshake_pid(input logic [3:0] p);
        return (p == PID_ACK) || (p == PID_NAK) || (p == PID_STALL);
    endfunction

    // USB sends bits LSB-first, so the shift register runs with the
    // bit-reversed polynomial.
    function automatic logic [15:0] reverse16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Combinational byte-wide USB CRC16 update (LSB-first, reflected 0x8005).
// Only instantiated when USB_TX_CRC16_EN is defined.
module usb_crc16
    import usb_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    localparam logic [15:0] POLY_REV = reverse16(CRC16_POLY);

    // Fold the byte in, then shift out eight bits least-significant first.
    always_comb begin
        crc_out = crc_in ^ {8'h00, data_in};
        for (int i = 0; i < 8; i++) begin
            if (crc_out[0]) crc_out = (crc_out >> 1) ^ POLY_REV;
            else            crc_out = crc_out >> 1;
        end
    end

endmodule

// File: rtl/usb_tx_packetizer.sv
// USB transmit packetizer: SYNC, PID, optional payload pulled from the packet
// buffer, then CRC16 low/high bytes when USB_TX_CRC16_EN is defined.
// Without the macro, data packets end on their last payload byte.
//
// Output handshake: byte_out/byte_last are valid while byte_valid is high and
// are held unchanged until the cycle byte_valid && byte_ready, which is the
// transfer; the FSM only advances on a transfer.
module usb_tx_packetizer
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_start,
    input  logic [3:0]  tx_pid,
    input  logic [6:0]  buffer_occupancy,
    output logic        get_tx_packet_data,
    input  logic [7:0]  tx_packet_data,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic        byte_last,
    input  logic        byte_ready,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        tx_err,
    output state_t      dbg_state
);

    state_t     state;
    logic [3:0] pid_q;
    logic [6:0] remaining;
    logic       xfer;
    logic       pop;

    assign xfer = byte_valid && byte_ready;
    // Pop only when the output slot is free or being emptied this cycle.
    assign pop  = (state == ST_DATA) && (remaining != 7'd0) && (!byte_valid || byte_ready);
    assign get_tx_packet_data = pop;
    assign dbg_state = state;

`ifdef USB_TX_CRC16_EN
    logic [15:0] crc;
    logic [15:0] crc_next;

    usb_crc16 u_crc16 (
        .crc_in  (crc),
        .data_in (tx_packet_data),
        .crc_out (crc_next)
    );
`endif

    // Packet FSM with registered byte stream and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pid_q      <= 4'h0;
            remaining  <= 7'd0;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            byte_last  <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_err     <= 1'b0;
`ifdef USB_TX_CRC16_EN
            crc        <= CRC16_INIT;
`endif
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_start) begin
                        if ((is_data_pid(tx_pid) || is_handshake_pid(tx_pid)) &&
                            (buffer_occupancy <= MAX_PAYLOAD)) begin
                            pid_q      <= tx_pid;
                            remaining  <= buffer_occupancy;
                            byte_out   <= SYNC_BYTE;
                            byte_valid <= 1'b1;
                            byte_last  <= 1'b0;
                            tx_busy    <= 1'b1;
                            state      <= ST_SYNC;
`ifdef USB_TX_CRC16_EN
                            crc        <= CRC16_INIT;
`endif
                        end else begin
                            tx_err <= 1'b1;
                        end
                    end
                end
                ST_SYNC: begin
                    if (xfer) begin
                        byte_out <= {~pid_q, pid_q};
`ifdef USB_TX_CRC16_EN
                        byte_last <= is_handshake_pid(pid_q);
`else
                        byte_last <= is_handshake_pid(pid_q) || (remaining == 7'd0);
`endif
                        state <= ST_PID;
                    end
                end
                ST_PID: begin
                    if (xfer) begin
                        if (byte_last) begin
                            byte_valid <= 1'b0;
                            byte_last  <= 1'b0;
                            tx_busy    <= 1'b0;
                            tx_done    <= 1'b1;
                            state      <= ST_IDLE;
                        end else if (remaining != 7'd0) begin
                            // Slot empties; the first pop happens next cycle.
                            byte_valid <= 1'b0;
                            byte_last  <= 1'b0;
                            state      <= ST_DATA;
                        end
`ifdef USB_TX_CRC16_EN
                        else begin
                            byte_out  <= ~crc[7:0];
                            byte_last <= 1'b0;
                            state     <= ST_CRC_LO;
                        end
`endif
                    end
                end
                ST_DATA: begin
                    if (pop) begin
                        byte_out   <= tx_packet_data;
                        byte_valid <= 1'b1;
                        remaining  <= remaining - 7'd1;
`ifdef USB_TX_CRC16_EN
                        crc        <= crc_next;
`else
                        byte_last  <= (remaining == 7'd1);
`endif
                    end else if (xfer) begin
                        // Last payload byte has been accepted.
`ifdef USB_TX_CRC16_EN
                        byte_out  <= ~crc[7:0];
                        byte_last <= 1'b0;
                        state     <= ST_CRC_LO;
`else
                        byte_valid <= 1'b0;
                        byte_last  <= 1'b0;
                        tx_busy    <= 1'b0;
                        tx_done    <= 1'b1;
                        state      <= ST_IDLE;
`endif
                    end
                end
`ifdef USB_TX_CRC16_EN
                ST_CRC_LO: begin
                    if (xfer) begin
                        byte_out  <= ~crc[15:8];
                        byte_last <= 1'b1;
                        state     <= ST_CRC_HI;
                    end
                end
                ST_CRC_HI: begin
                    if (xfer) begin
                        byte_valid <= 1'b0;
                        byte_last  <= 1'b0;
                        tx_busy    <= 1'b0;
                        tx_done    <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// Testbench for usb_tx_packetizer. Expected byte streams are queued when a
// request is driven and popped as the DUT transfers bytes. Follows the
// USB_TX_CRC16_EN setting of the build.
module tb_usb_tx_packetizer;
    import usb_pkg::*;

    // ---------------- clock / reset / signals ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [3:0] tx_pid;
    logic [6:0] buffer_occupancy;
    logic       get_tx_packet_data;
    logic [7:0] tx_packet_data = 8'h00;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_last;
    logic       byte_ready = 1'b1;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;
    state_t     dbg_state;

    always #5 clk = ~clk;

    usb_tx_packetizer dut (
        .clk                (clk),
        .rst                (rst),
        .tx_start           (tx_start),
        .tx_pid             (tx_pid),
        .buffer_occupancy   (buffer_occupancy),
        .get_tx_packet_data (get_tx_packet_data),
        .tx_packet_data     (tx_packet_data),
        .byte_out           (byte_out),
        .byte_valid         (byte_valid),
        .byte_last          (byte_last),
        .byte_ready         (byte_ready),
        .tx_busy            (tx_busy),
        .tx_done            (tx_done),
        .tx_err             (tx_err),
        .dbg_state          (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] exp_q[$];          // {last, byte}
    logic [7:0] buf_q[$];          // packet buffer contents
    logic [7:0] pkt_data[64];
    int         ready_mode = 0;    // 0: held high, 1: toggling, 2: random
    int         cycle = 0;
    int         pop_count = 0;
    int         first_pop = -1;
    int         last_pop = -1;
    int         done_seen = 0;
    logic       pop_pend = 1'b0;
    logic       stall_prev = 1'b0;
    logic [8:0] stall_val = 9'h000;
    logic       done_expect = 1'b0;
    logic       err_allowed = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Buffer pop and byte_ready driving, just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (pop_pend && buf_q.size() != 0) void'(buf_q.pop_front());
        tx_packet_data = (buf_q.size() != 0) ? buf_q[0] : 8'h00;
        case (ready_mode)
            0:       byte_ready = 1'b1;
            1:       byte_ready = ~byte_ready;
            default: byte_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor on the falling edge: transfers, pops, holds, status pulses.
    always @(negedge clk) begin
        logic [8:0] e;
        cycle++;
        pop_pend = 1'b0;
        if (!rst) begin
            if (get_tx_packet_data) begin
                pop_pend = 1'b1;
                pop_count++;
                if (first_pop < 0) first_pop = cycle;
                last_pop = cycle;
                if (byte_valid && !byte_ready) check("pop_while_stalled", 1, 0);
            end
            if (stall_prev) check("hold_byte", 32'({byte_last, byte_out}), 32'(stall_val));
            if (done_expect) begin
                check("tx_done", 32'(tx_done), 1);
                if (tx_done) done_seen++;
                done_expect = 1'b0;
            end else if (tx_done) begin
                check("tx_done_spurious", 1, 0);
            end
            if (tx_err && !err_allowed) check("tx_err_spurious", 1, 0);
            if (byte_valid && byte_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'({byte_last, byte_out}), 32'h1000);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", 32'({byte_last, byte_out}), 32'(e));
                    if (e[8]) done_expect = 1'b1;
                end
            end
            stall_prev = byte_valid && !byte_ready;
            stall_val  = {byte_last, byte_out};
        end else begin
            stall_prev  = 1'b0;
            done_expect = 1'b0;
        end
    end

    // ---------------- reference model ----------------
`ifdef USB_TX_CRC16_EN
    function automatic logic [15:0] usb_crc_ref(input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ pkt_data[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return ~c;
    endfunction
`endif

    task automatic push_exp(input logic last, input logic [7:0] b);
        exp_q.push_back({last, b});
    endtask

    task automatic load_buffer(input int n);
        for (int i = 0; i < n; i++) buf_q.push_back(pkt_data[i]);
    endtask

    task automatic queue_model(input logic [3:0] pid, input int n);
        logic hs;
`ifdef USB_TX_CRC16_EN
        logic [15:0] crc;
`endif
        hs = (pid == 4'b0010) || (pid == 4'b1010) || (pid == 4'b1110);
        push_exp(1'b0, 8'h80);
`ifdef USB_TX_CRC16_EN
        push_exp(hs, {~pid, pid});
        if (!hs) begin
            for (int i = 0; i < n; i++) push_exp(1'b0, pkt_data[i]);
            crc = usb_crc_ref(n);
            push_exp(1'b0, crc[7:0]);
            push_exp(1'b1, crc[15:8]);
        end
`else
        push_exp(hs || (n == 0), {~pid, pid});
        if (!hs) for (int i = 0; i < n; i++) push_exp(i == n - 1, pkt_data[i]);
`endif
        if (!hs) load_buffer(n);
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_and_wait(input logic [3:0] pid, input int n, input int mode,
                                  input logic mid_start);
        logic finished;
        ready_mode = mode;
        pop_count  = 0;
        first_pop  = -1;
        last_pop   = -1;
        done_seen  = 0;
        @(posedge clk); #2;
        tx_start = 1'b1;
        tx_pid = pid;
        buffer_occupancy = 7'(n);
        @(posedge clk); #2;
        tx_start = 1'b0;
        check("tx_busy_after_start", 32'(tx_busy), 1);
        finished = 1'b0;
        for (int k = 0; k < 400 && !finished; k++) begin
            @(posedge clk); #2;
            tx_start = mid_start && (k == 3);
            tx_pid = PID_ACK;
            buffer_occupancy = 7'd0;
            finished = (exp_q.size() == 0) && (done_seen > 0);
        end
        tx_start = 1'b0;
        check("packet_complete", 32'({exp_q.size() == 0, done_seen > 0}), 32'h3);
        check("pop_count", 32'(pop_count), 32'(is_data_pid(pid) ? n : 0));
        check("tx_busy_after_done", 32'(tx_busy), 0);
        if (mode == 0 && n > 0 && is_data_pid(pid))
            check("pop_spacing", 32'(last_pop - first_pop), 32'(n - 1));
        exp_q.delete();
        buf_q.delete();
    endtask

    task automatic run_packet(input logic [3:0] pid, input int n, input int mode,
                              input logic mid_start);
        queue_model(pid, n);
        start_and_wait(pid, n, mode, mid_start);
    endtask

    task automatic err_test(input logic [3:0] pid, input int n);
        err_allowed = 1'b1;
        @(posedge clk); #2;
        tx_start = 1'b1;
        tx_pid = pid;
        buffer_occupancy = 7'(n);
        @(posedge clk); #2;
        tx_start = 1'b0;
        check("tx_err_pulse", 32'(tx_err), 1);
        check("err_no_valid", 32'(byte_valid), 0);
        check("err_not_busy", 32'(tx_busy), 0);
        @(posedge clk); #2;
        check("tx_err_cleared", 32'(tx_err), 0);
        check("err_no_valid_later", 32'(byte_valid), 0);
        err_allowed = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_byte_out"}, 32'(byte_out), 0);
        check({tag, "_byte_valid"}, 32'(byte_valid), 0);
        check({tag, "_byte_last"}, 32'(byte_last), 0);
        check({tag, "_tx_busy"}, 32'(tx_busy), 0);
        check({tag, "_tx_done"}, 32'(tx_done), 0);
        check({tag, "_tx_err"}, 32'(tx_err), 0);
        check({tag, "_pop"}, 32'(get_tx_packet_data), 0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        tx_start = 1'b0;
        tx_pid = 4'h0;
        buffer_occupancy = 7'd0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        rst = 1'b0;

        // ACK: 80, D2, no pops
        run_packet(PID_ACK, 0, 0, 1'b0);

        // DATA0 with 31..39: explicit expected stream
        for (int i = 0; i < 9; i++) pkt_data[i] = 8'h31 + 8'(i);
        load_buffer(9);
        push_exp(1'b0, 8'h80);
        push_exp(1'b0, 8'hC3);
`ifdef USB_TX_CRC16_EN
        for (int i = 0; i < 9; i++) push_exp(1'b0, 8'h31 + 8'(i));
        push_exp(1'b0, 8'hC8);
        push_exp(1'b1, 8'hB4);
`else
        for (int i = 0; i < 9; i++) push_exp(i == 8, 8'h31 + 8'(i));
`endif
        start_and_wait(PID_DATA0, 9, 0, 1'b0);

        // DATA1 with empty payload
        run_packet(PID_DATA1, 0, 0, 1'b0);

        // DATA0, 3 bytes, toggling ready, with an ignored mid-packet start
        for (int i = 0; i < 3; i++) pkt_data[i] = 8'($urandom_range(0, 255));
        run_packet(PID_DATA0, 3, 1, 1'b1);

        // Other handshakes under random backpressure
        run_packet(PID_NAK, 0, 2, 1'b0);
        run_packet(PID_STALL, 0, 2, 1'b0);

        // Single byte and full 64-byte payloads
        pkt_data[0] = 8'hA5;
        run_packet(PID_DATA1, 1, 0, 1'b0);
        for (int i = 0; i < 64; i++) pkt_data[i] = 8'($urandom_range(0, 255));
        run_packet(PID_DATA1, 64, 2, 1'b0);
        run_packet(PID_DATA0, 64, 0, 1'b0);

        // Rejected requests
        err_test(4'b0001, 0);
        err_test(PID_DATA0, 65);

        // Reset in the middle of a data packet
        for (int i = 0; i < 5; i++) pkt_data[i] = 8'h50 + 8'(i);
        queue_model(PID_DATA0, 5);
        ready_mode = 0;
        pop_count = 0;
        @(posedge clk); #2;
        tx_start = 1'b1;
        tx_pid = PID_DATA0;
        buffer_occupancy = 7'd5;
        @(posedge clk); #2;
        tx_start = 1'b0;
        for (int k = 0; k < 50 && pop_count < 2; k++) begin
            @(posedge clk); #2;
        end
        check("reached_data", 32'(dbg_state == ST_DATA), 1);
        rst = 1'b1;
        @(posedge clk); #2;
        check_all_zero("mid_reset");
        rst = 1'b0;
        exp_q.delete();
        buf_q.delete();

        // Clean ACK afterwards
        run_packet(PID_ACK, 0, 0, 1'b0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
